gate_vector_seq: RTL and testbench

GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

---
 rtl/gate_vector_seq_pkg.sv | 30 +++
 rtl/gate_seq_debounce.sv | 60 ++++++
 rtl/gate_vector_seq.sv | 138 +++++++++++++
 tb/tb_gate_vector_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gate_vector_seq_pkg.sv
// gate_vector_seq_pkg: shared state encoding, parameter defaults and io_out bit map
// for the gate vector sequencer.
`default_nettype none

package gate_vector_seq_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int AUTO_DIV_DEF   = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_AUTO   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int OUT_VEC_LSB = 0;
  localparam int OUT_VEC_MSB = 2;
  localparam int OUT_AND     = 3;
  localparam int OUT_OR      = 4;
  localparam int OUT_XOR     = 5;
  localparam int OUT_DONE    = 6;
  localparam int OUT_BUSY    = 7;

  // Returns {a^b^c, a|c, b&c} for vector {c,b,a}, matching io_out[5:3].
  function automatic logic [2:0] gate_bits(input logic [2:0] v);
    return {^v, v[0] | v[2], v[1] & v[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_seq_debounce.sv
// gate_seq_debounce: 2-flop synchronizer, counting debouncer and rising-edge pulse
// for an asynchronous, bouncy, active-high button.
`default_nettype none

module gate_seq_debounce
  import gate_vector_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          warm1;
  logic          warm2;
  logic          stable;
  logic          armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      warm1  <= 1'b0;
      warm2  <= 1'b0;
      stable <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      warm1 <= 1'b1;
      warm2 <= warm1;
      pulse <= 1'b0;
      // Only arm once a genuine low has flushed through the synchronizer, so a
      // button held across reset release cannot fire.
      if (warm2 && !sync2 && !stable)
        armed <= 1'b1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        pulse  <= sync2 & armed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gate_vector_seq.sv
// gate_vector_seq: steps a 3-bit vector manually or automatically and drives
// registered AND/OR/XOR results of it, plus done and busy flags.
`default_nettype none

module gate_vector_seq
  import gate_vector_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int AUTO_DIV   = AUTO_DIV_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  logic clk;
  logic rst_n;
  logic unused_inputs;

  assign clk           = io_in[0];
  assign rst_n         = io_in[1];
  assign unused_inputs = ^io_in[7:4];

  logic          step;
  logic          auto_s1;
  logic          auto_s2;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [2:0]    vec;
  logic [2:0]    vec_nx;
  logic [2:0]    gates;
  logic          done;
  logic          done_nx;
  logic          busy;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic          adv;

  gate_seq_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(io_in[2]),
    .pulse   (step)
  );

  always_comb begin
    adv      = 1'b0;
    state_nx = state;
    presc_nx = presc;
    done_nx  = done;
    vec_nx   = vec;
    case (state)
      ST_IDLE: begin
        if (auto_s2) begin
          state_nx = ST_AUTO;
          presc_nx = '0;
        end else if (step) begin
          state_nx = ST_MANUAL;
          adv      = 1'b1;
        end
      end
      ST_MANUAL: begin
        if (auto_s2) begin
          state_nx = ST_AUTO;
          presc_nx = '0;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      ST_AUTO: begin
        // Leaving auto mode takes priority over a coincident terminal count.
        if (!auto_s2) begin
          state_nx = ST_MANUAL;
        end else if (presc == PW'(AUTO_DIV - 1)) begin
          presc_nx = '0;
          adv      = 1'b1;
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      ST_DONE: begin
        if (step) begin
          done_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (adv) begin
      if (vec == 3'b111) begin
        vec_nx   = 3'b000;
        done_nx  = 1'b1;
        state_nx = ST_DONE;
      end else begin
        vec_nx = vec + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      state   <= ST_IDLE;
      vec     <= 3'b000;
      gates   <= 3'b000;
      done    <= 1'b0;
      busy    <= 1'b0;
      presc   <= '0;
    end else begin
      auto_s1 <= io_in[3];
      auto_s2 <= auto_s1;
      state   <= state_nx;
      vec     <= vec_nx;
      gates   <= gate_bits(vec_nx);
      done    <= done_nx;
      busy    <= (state_nx == ST_MANUAL) || (state_nx == ST_AUTO);
      presc   <= presc_nx;
    end
  end

  always_comb begin
    io_out                          = '0;
    io_out[OUT_VEC_MSB:OUT_VEC_LSB] = vec;
    io_out[OUT_AND]                 = gates[0];
    io_out[OUT_OR]                  = gates[1];
    io_out[OUT_XOR]                 = gates[2];
    io_out[OUT_DONE]                = done;
    io_out[OUT_BUSY]                = busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_seq.sv
// tb_gate_vector_seq: directed self-checking bench for gate_vector_seq.
`default_nettype none

module tb_gate_vector_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       step  = 1'b0;
  logic       auto  = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         checks = 0;
  int         errors = 0;

  assign io_in = {4'b0000, auto, step, rst_n, clk};

  gate_vector_seq #(
    .DEB_CYCLES(4),
    .AUTO_DIV  (8)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Expected io_out for vectors 001..111 while busy.
  logic [7:0] auto_exp [1:7];

  initial begin
    auto_exp[1] = 8'hB1;
    auto_exp[2] = 8'hA2;
    auto_exp[3] = 8'h93;
    auto_exp[4] = 8'hB4;
    auto_exp[5] = 8'h95;
    auto_exp[6] = 8'h9E;
    auto_exp[7] = 8'hBF;

    tick(3);
    check("reset_state", io_out, 8'h00);
    rst_n = 1'b1;
    tick(20);
    check("idle_20", io_out, 8'h00);

    // Clean press: advance lands on the 7th edge after the rise.
    step = 1'b1;
    tick(6);
    check("press_edge6", io_out, 8'h00);
    tick(1);
    check("press_edge7", io_out, 8'hB1);
    tick(3);
    check("press_held", io_out, 8'hB1);
    step = 1'b0;
    tick(10);
    check("press_once", io_out, 8'hB1);

    // Bounce 1,0,1,0 then steady 1: one advance timed from the last rise.
    step = 1'b1; tick(1);
    step = 1'b0; tick(1);
    step = 1'b1; tick(1);
    step = 1'b0; tick(1);
    step = 1'b1;
    tick(6);
    check("bounce_edge6", io_out, 8'hB1);
    tick(1);
    check("bounce_edge7", io_out, 8'hA2);
    tick(5);
    step = 1'b0;
    tick(10);
    check("bounce_once", io_out, 8'hA2);

    step = 1'b1;
    tick(8);
    step = 1'b0;
    tick(10);
    check("press_to_011", io_out, 8'h93);

    // Reset in the middle of a debounce count, button held through release.
    step = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check("mid_deb_reset", io_out, 8'h00);
    rst_n = 1'b1;
    tick(15);
    check("held_thru_reset", io_out, 8'h00);
    step = 1'b0;
    tick(10);
    check("release_after_rst", io_out, 8'h00);
    step = 1'b1;
    tick(7);
    check("rearmed_press", io_out, 8'hB1);
    step = 1'b0;
    tick(10);

    // Drop auto so its synchronized low meets the prescaler terminal cycle.
    auto = 1'b1;
    tick(8);
    auto = 1'b0;
    tick(3);
    check("auto_drop_tc", io_out, 8'hB1);
    tick(10);
    check("manual_no_auto", io_out, 8'hB1);
    step = 1'b1;
    tick(7);
    check("manual_step", io_out, 8'hA2);
    step = 1'b0;
    tick(10);

    // Full automatic run from IDLE.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    auto = 1'b1;
    tick(10);
    check("auto_start", io_out, 8'h80);
    tick(1);
    check("auto_v1", io_out, auto_exp[1]);
    for (int k = 2; k <= 7; k++) begin
      tick(7);
      check($sformatf("auto_hold_v%0d", k - 1), io_out, auto_exp[k-1]);
      tick(1);
      check($sformatf("auto_v%0d", k), io_out, auto_exp[k]);
    end
    tick(7);
    check("auto_hold_v7", io_out, 8'hBF);
    tick(1);
    check("auto_done", io_out, 8'h40);
    tick(20);
    check("done_hold", io_out, 8'h40);

    // Step pulse leaves DONE to IDLE without advancing; next one advances.
    auto = 1'b0;
    tick(5);
    step = 1'b1;
    tick(7);
    check("done_to_idle", io_out, 8'h00);
    step = 1'b0;
    tick(10);
    step = 1'b1;
    tick(7);
    check("idle_to_manual", io_out, 8'hB1);
    step = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
